if_fetch_unit: RTL

Instruction fetch stage for the RV32I core. It sits between the PC register and decode. It consumes the current `pc`, drives `pc_nxt` back to the PC register, and issues word requests to instruction memory over a valid/ready handshake. It buffers returned instructions with their PCs in an in-order ring buffer, and flushes and redirects when execute resolves a taken branch or jump.

---
 rtl/rv32_fetch_pkg.sv | 20 ++
 rtl/fetch_ring_buffer.sv | 81 ++++++++
 rtl/if_fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
//   XLEN / ILEN   : address and instruction widths
//   PC_STEP       : sequential PC increment in bytes
//   INST_NOP      : canonical NOP (addi x0,x0,0), used as the empty-slot value
//   fetch_entry_t : one ring-buffer slot {pc, data, filled}
package rv32_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] data;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ring_buffer.sv
// In-order ring buffer of fetch slots. A slot is allocated when its request
// is accepted, filled when the response returns, and popped by decode.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_flush           : drop every slot and rewind all pointers
//   i_alloc/_pc       : allocate the slot at alloc_ptr for fetch address _pc
//   i_fill/_data      : write the response into the slot at fill_ptr
//   i_pop             : release the head slot
//   o_head            : slot at pop_ptr
//   o_count           : allocated slots (0..DEPTH)
//   o_unfilled        : allocated slots still waiting for their response
module fetch_ring_buffer
    import rv32_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_flush,
    input  logic                        i_alloc,
    input  logic [XLEN-1:0]             i_alloc_pc,
    input  logic                        i_fill,
    input  logic [ILEN-1:0]             i_fill_data,
    input  logic                        i_pop,
    output fetch_entry_t                o_head,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [$clog2(DEPTH):0]      o_unfilled
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t        r_entries [DEPTH];
    // Pointers carry one wrap bit so alloc - fill distinguishes 0 from DEPTH.
    logic [CW-1:0]       r_alloc_ptr;
    logic [CW-1:0]       r_fill_ptr;
    logic [CW-1:0]       r_pop_ptr;
    logic [CW-1:0]       r_count;

    logic [AW-1:0]       w_alloc_idx;
    logic [AW-1:0]       w_fill_idx;
    logic [AW-1:0]       w_pop_idx;

    assign w_alloc_idx = r_alloc_ptr[AW-1:0];
    assign w_fill_idx  = r_fill_ptr[AW-1:0];
    assign w_pop_idx   = r_pop_ptr[AW-1:0];

    // Slot storage and pointer/count bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[AW'(i)] <= '{pc: '0, data: INST_NOP, filled: 1'b0};
            end
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_count     <= '0;
        end else begin
            if (i_pop) begin
                r_entries[w_pop_idx].filled <= 1'b0;
            end
            if (i_alloc) begin
                r_entries[w_alloc_idx].pc     <= i_alloc_pc;
                r_entries[w_alloc_idx].filled <= 1'b0;
            end
            if (i_fill) begin
                r_entries[w_fill_idx].data   <= i_fill_data;
                r_entries[w_fill_idx].filled <= 1'b1;
            end
            r_alloc_ptr <= r_alloc_ptr + CW'(i_alloc);
            r_fill_ptr  <= r_fill_ptr  + CW'(i_fill);
            r_pop_ptr   <= r_pop_ptr   + CW'(i_pop);
            r_count     <= r_count + CW'(i_alloc) - CW'(i_pop);
        end
    end

    assign o_head     = r_entries[w_pop_idx];
    assign o_count    = r_count;
    assign o_unfilled = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: issues word fetches at pc, steers pc_nxt,
// buffers responses in order and flushes on an execute redirect. Responses
// belonging to flushed requests are counted in drop_cnt and discarded.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   pc / pc_nxt                : current PC in, next PC out
//   imem_req_valid/ready/addr  : fetch request handshake
//   imem_rsp_valid/data        : in-order response, no backpressure
//   redirect_valid/pc          : flush and restart at redirect_pc
//   inst_valid/ready, inst, inst_pc : instruction stream to decode
module if_fetch_unit
    import rv32_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_nxt,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [ILEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Headroom: repeated redirects can stack flushed responses past DEPTH.
    localparam int unsigned DW = CW + 1;

    fetch_entry_t     w_head;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_unfilled;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_drop;
    logic             w_fill;
    logic             w_inst_valid;
    logic             w_pop;
    logic [XLEN-1:0]  w_fetch_addr;
    logic             w_unused_redirect_lsbs;
    logic [DW-1:0]    r_drop_cnt;

    assign w_unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    assign w_fetch_addr = {pc[XLEN-1:2], 2'b00};
    // Issue depends only on registered count, never on inst_ready.
    assign w_req_valid  = !reset && !redirect_valid && (w_count < CW'(DEPTH));
    assign w_req_fire   = w_req_valid && imem_req_ready;
    assign w_rsp_drop   = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_fill       = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid && !reset;
    assign w_inst_valid = !reset && w_head.filled && (w_count != '0);
    assign w_pop        = w_inst_valid && inst_ready && !redirect_valid;

    fetch_ring_buffer #(
        .DEPTH       (DEPTH)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (redirect_valid),
        .i_alloc     (w_req_fire),
        .i_alloc_pc  (w_fetch_addr),
        .i_fill      (w_fill),
        .i_fill_data (imem_rsp_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_unfilled  (w_unfilled)
    );

    // Next-PC select: redirect beats sequential advance beats hold.
    always_comb begin
        pc_nxt = pc;
        if (reset) begin
            pc_nxt = pc;
        end else if (redirect_valid) begin
            pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_req_fire) begin
            pc_nxt = pc + XLEN'(PC_STEP);
        end
    end

    // Responses still owed for flushed requests; a response arriving in the
    // redirect cycle is one of them and is retired immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_drop_cnt <= r_drop_cnt + DW'(w_unfilled) - DW'(imem_rsp_valid);
        end else if (w_rsp_drop) begin
            r_drop_cnt <= r_drop_cnt - DW'(1);
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = reset ? '0 : w_fetch_addr;
    assign inst_valid     = w_inst_valid;
    assign inst           = reset ? '0 : w_head.data;
    assign inst_pc        = reset ? '0 : w_head.pc;

endmodule
